jk_cmd_sequencer: RTL
=====================

// Module: jk_cmd_sequencer
// PURPOSE
//  Upstream driver for a JK flip-flop stage. Accepts JK operations (hold/clear/set/toggle) plus a
//  repeat count over a valid/ready interface and buffers them in a small FIFO. It then drives
//  registered J/K outputs for the requested number of cycles.
//  Also keeps q_model, a cycle-accurate prediction of the downstream flip-flop's Q, for checking/readback.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >=2
//  CW     4  width of cmd_count; repeat range 1..2**CW
// PORTS
//  clk        in   1      single clock; all state updates on posedge clk
//  reset      in   1      asynchronous, active-low; clears all state immediately on assertion
//  flush      in   1      synchronous clear of FIFO and sequencer, active-high
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      FIFO can accept; = !full
//  cmd_op     in   2      00 hold, 01 clear, 10 set, 11 toggle  (maps directly to {J,K})
//  cmd_count  in   CW     cycles to apply op; 0 means 2**CW
//  J          out  1      registered J to downstream JK flip-flop
//  K          out  1      registered K to downstream JK flip-flop
//  busy       out  1      high while state==APPLY
//  done       out  1      one-cycle pulse after the final applied cycle of each command
//  q_model    out  1      predicted downstream Q (downstream flip-flop reset alongside this block)
//  level      out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (reset=0): J=K=0, busy=0, done=0, q_model=0, FIFO empty (level=0, cmd_ready=1), state IDLE.
//  Push: entry written at the edge where cmd_valid&&cmd_ready. No push when full; no bypass when empty.
//  FSM states: IDLE, APPLY.
//   IDLE: if FIFO non-empty, pop at edge. Load {J,K}=op and rem=(count-1) mod 2**CW. Go to APPLY.
//         Otherwise J=K=0.
//   APPLY: J/K held. Each edge with rem!=0 does rem-=1.
//          At an edge with rem==0 the last cycle ends and done=1 for the next cycle.
//          If the FIFO is non-empty, pop and load the next command in the same edge: no bubble, stay APPLY.
//          If the FIFO is empty, set J=K=0 and go to IDLE.
//  Latency: push at edge n into empty idle block -> J/K valid cycles n+1..n+count. Total cmd_count cycles.
//  q_model: each edge applies JK rule to registered J/K of the ending cycle:
//           00 keep, 01 ->0, 10 ->1, 11 invert.
//  Simultaneous push+pop: permitted when not full; level unchanged.
//  Pop never occurs when empty.
//  flush=1 at an edge:
//   - FIFO emptied, state IDLE, J=K=0, done=0, rem=0.
//   - q_model still updates from the ending cycle's J/K.
//   - A concurrent push is dropped.
//  Asynchronous reset mid-command: immediate return to reset values; the command in flight is discarded.
// CONFIGURATION
//  Macro JK_SEQ_STATS_EN:
//   - Defined: adds output stat_toggles [15:0], reset 0, flush does not clear.
//     It increments once per edge at which J=K=1 was applied and saturates at 16'hFFFF.
//   - Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package jk_seq_pkg: typedef enum logic[1:0] jk_op_t {OP_HOLD,OP_CLR,OP_SET,OP_TOG};
//  typedef enum logic seq_state_t {IDLE,APPLY}; function jk_next(q,op) shared by RTL q_model and the bench.
//  Sub-module jk_cmd_fifo: synchronous FIFO (DEPTH x (2+CW)) with push/pop/flush, full/empty/level.
//  The sequencer FSM, rem counter and q_model sit in the top module.
// TESTING
//  1 reset released; push SET,count=3 at edge 0 -> J=1,K=0 cycles 1..3.
//    q_model=1 from edge 2; done pulse cycle 4; busy low cycle 4.
//  2 back-to-back TOG c=2 then CLR c=1 queued -> JK=11,11,01 contiguous.
//    q_model 0->1->0->0; done at cycles after each command's last cycle; no idle gap.
//  3 push 4 commands while first is applying, DEPTH=4 -> cmd_ready low when level=4.
//    5th valid stalls until a pop; no command lost or duplicated.
//  4 cmd_count=0 with TOG -> 16 cycles of JK=11; q_model ends at its starting value.
//  5 flush during APPLY of SET c=8 at cycle 3, FIFO holding 2 entries -> J=K=0 next cycle, level=0, no done.
//  6 reset asserted asynchronously mid-TOG -> J,K,q_model,busy,level zero before next clk edge.
//    With JK_SEQ_STATS_EN, stat_toggles counts 11-cycles exactly (e.g. 5 after test 2+3 mix).

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types and the JK next-state rule for the JK command sequencer.
package jk_seq_pkg;

    typedef enum logic [1:0] {OP_HOLD = 2'b00, OP_CLR = 2'b01, OP_SET = 2'b10, OP_TOG = 2'b11} jk_op_t;

    typedef enum logic {IDLE = 1'b0, APPLY = 1'b1} seq_state_t;

    function automatic logic jk_next(input logic q, input jk_op_t op);
        case (op)
            OP_HOLD: jk_next = q;
            OP_CLR:  jk_next = 1'b0;
            OP_SET:  jk_next = 1'b1;
            default: jk_next = ~q;
        endcase
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with push/pop/flush and occupancy level.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 6,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push && !full) - LW'(pop && !empty);
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers JK commands and drives registered J/K for each command's repeat count; tracks predicted Q.
// Optional macro JK_SEQ_STATS_EN adds the saturating stat_toggles counter output.
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 4,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_count,
    output logic          J,
    output logic          K,
    output logic          busy,
    output logic          done,
    output logic          q_model,
    output logic [LW-1:0] level
`ifdef JK_SEQ_STATS_EN
    ,
    output logic [15:0]   stat_toggles
`endif
);

    localparam int DW = 2 + CW;

    seq_state_t    state;
    logic [CW-1:0] rem;
    logic [DW-1:0] rd_data;
    logic          full, empty, push, pop;
    logic [1:0]    rd_op;
    logic [CW-1:0] rd_cnt;

    assign cmd_ready = !full;
    assign push      = cmd_valid && !full && !flush;
    // Pop on the edge that starts a command: from IDLE, or on the last cycle of the current one.
    assign pop       = !flush && !empty && (state == IDLE || rem == '0);
    assign rd_op     = rd_data[DW-1 -: 2];
    assign rd_cnt    = rd_data[CW-1:0];

    jk_cmd_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (push),
        .wr_data ({cmd_op, cmd_count}),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rem     <= '0;
            J       <= 1'b0;
            K       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            q_model <= 1'b0;
        end else begin
            // Q follows the J/K of the cycle ending at this edge, flush or not.
            q_model <= jk_next(q_model, jk_op_t'({J, K}));
            if (flush) begin
                state <= IDLE;
                rem   <= '0;
                J     <= 1'b0;
                K     <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                done <= 1'b0;
                case (state)
                    IDLE: begin
                        if (!empty) begin
                            {J, K} <= rd_op;
                            rem    <= rd_cnt - CW'(1);
                            state  <= APPLY;
                            busy   <= 1'b1;
                        end else begin
                            J <= 1'b0;
                            K <= 1'b0;
                        end
                    end
                    default: begin
                        if (rem != '0) begin
                            rem <= rem - CW'(1);
                        end else begin
                            done <= 1'b1;
                            if (!empty) begin
                                {J, K} <= rd_op;
                                rem    <= rd_cnt - CW'(1);
                            end else begin
                                J     <= 1'b0;
                                K     <= 1'b0;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef JK_SEQ_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stat_toggles <= '0;
        else if (J && K && stat_toggles != 16'hFFFF)
            stat_toggles <= stat_toggles + 16'd1;
    end
`endif

endmodule
